// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals of the shared-UART arbiter
// The slave modport is the arbiter's view; master is the view of the clients and transmitter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              timeout_err;
    logic              busy;
    logic              tx_start;
    logic [7:0]        tx_din;
    logic              tx_done_tick;

    modport slave (
        input  req,
        input  req_data,
        input  tx_done_tick,
        output grant,
        output done,
        output timeout_err,
        output busy,
        output tx_start,
        output tx_din
    );

    modport master (
        output req,
        output req_data,
        output tx_done_tick,
        input  grant,
        input  done,
        input  timeout_err,
        input  busy,
        input  tx_start,
        input  tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one 8N1 UART transmitter with a done watchdog
// IDLE picks a requester, START strobes the transmitter, WAIT waits for done, DONE pulses the result.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]   ptr, ptr_d;
    logic [PW-1:0]   owner, owner_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            terr_q, terr_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic [7:0]      din_q, din_d;

    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic            timeout_hit;

    // Walk the search order backwards so the position closest to ptr is the last one written.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (bus.req[idx]) begin
                win_valid = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    assign timeout_hit = WD_EN && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_valid) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (bus.tx_done_tick || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of every registered output; a done tick on the last watchdog cycle still counts as done.
    always_comb begin
        ptr_d   = ptr;
        owner_d = owner;
        cnt_d   = cnt;
        grant_d = grant_q;
        done_d  = done_q;
        terr_d  = terr_q;
        busy_d  = busy_q;
        start_d = start_q;
        din_d   = din_q;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    owner_d = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    din_d   = bus.req_data[int'(win_idx) * 8 +: 8];
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                start_d = 1'b0;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (bus.tx_done_tick) begin
                    done_d = grant_q;
                end else if (timeout_hit) begin
                    terr_d = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DONE: begin
                done_d  = '0;
                terr_d  = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            grant_q <= '0;
            done_q  <= '0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            din_q   <= '0;
        end else begin
            ptr     <= ptr_d;
            owner   <= owner_d;
            cnt     <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            din_q   <= din_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = busy_q;
    assign bus.tx_start    = start_q;
    assign bus.tx_din      = din_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter against a transfer-level model
// Directed literal scenarios first, then randomized requesters and transmitter ticks.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic reset;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: owner, sampling edge t0, and the edge at which the transfer ended.
    int         cyc     = 0;
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_t0    = 0;
    int         m_end   = -1;
    bit         m_ok    = 1'b0;
    logic [7:0] m_data  = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_end   = -1;
            m_ok    = 1'b0;
            m_data  = 8'h00;
        end else begin
            cyc = cyc + 1;
            if (m_owner < 0) begin
                int w;
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                if (w >= 0) begin
                    m_owner = w;
                    m_t0    = cyc;
                    m_data  = bus.req_data[8*w +: 8];
                    m_end   = -1;
                end
            end else if (m_end < 0) begin
                if (cyc >= m_t0 + 2) begin
                    if (bus.tx_done_tick === 1'b1) begin
                        m_end = cyc;
                        m_ok  = 1'b1;
                    end else if (cyc == m_t0 + 1 + TIMEOUT) begin
                        m_end = cyc;
                        m_ok  = 1'b0;
                    end
                end
            end else if (cyc == m_end + 1) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            int eg;
            eg = (m_owner >= 0) ? (1 << m_owner) : 0;
            chk("grant", 32'(bus.grant), 32'(eg));
            chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
            chk("tx_start", 32'(bus.tx_start), 32'(m_owner >= 0 && cyc == m_t0));
            chk("tx_din", 32'(bus.tx_din), 32'(m_data));
            chk("done", 32'(bus.done), (m_owner >= 0 && m_end == cyc && m_ok) ? 32'(eg) : 32'd0);
            chk("timeout_err", 32'(bus.timeout_err), 32'(m_owner >= 0 && m_end == cyc && !m_ok));
        end
    end

    // Transmitter stub: 0 random, 1 never, 2 one tick at t0+tick_off, 3 always high.
    int tick_mode = 1;
    int tick_off  = 5;
    int tick_div  = 4;

    always @(negedge clk) begin
        case (tick_mode)
            0:       bus.tx_done_tick = ($urandom_range(0, tick_div - 1) == 0);
            2:       bus.tx_done_tick = (m_owner >= 0 && cyc == m_t0 + tick_off);
            3:       bus.tx_done_tick = 1'b1;
            default: bus.tx_done_tick = 1'b0;
        endcase
    end

    task automatic wait_start();
        int i;
        i = 0;
        while (bus.tx_start !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("start_seen", 32'(bus.tx_start), 32'd1);
    endtask

    task automatic wait_end(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.done == '0 && bus.timeout_err !== 1'b1 && cycles < 300);
        chk("end_seen", 32'(bus.done != '0 || bus.timeout_err === 1'b1), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [NREQ-1:0] rr_grant [5];
        logic [7:0]      rr_din   [5];

        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_din", 32'(bus.tx_din), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_terr", 32'(bus.timeout_err), 32'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Single request from requester 2 with a fixed transmitter time.
        @(negedge clk);
        tick_mode    = 2;
        tick_off     = 5;
        bus.req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
        bus.req      = 4'b0100;
        @(negedge clk);
        chk("single_start", 32'(bus.tx_start), 32'd1);
        chk("single_grant", 32'(bus.grant), 32'h4);
        chk("single_din", 32'(bus.tx_din), 32'hA5);
        wait_end(n);
        chk("single_latency", 32'(n), 32'd6);
        chk("single_done", 32'(bus.done), 32'h4);
        bus.req = '0;
        @(negedge clk);
        chk("single_idle", 32'(bus.busy), 32'd0);

        // Round robin with everyone requesting, starting from ptr 0.
        pulse_reset();
        tick_mode    = 0;
        tick_div     = 4;
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req      = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            rr_grant[j] = 4'b0001 << (j % 4);
            rr_din[j]   = 8'h10 + 8'(j % 4);
            wait_start();
            chk("rr_grant", 32'(bus.grant), 32'(rr_grant[j]));
            chk("rr_din", 32'(bus.tx_din), 32'(rr_din[j]));
            @(negedge clk);
        end
        bus.req = '0;
        wait_end(n);
        repeat (3) @(negedge clk);

        // Wrap: after requester 2, 0 beats 2 (search 3,0), then 2 runs.
        pulse_reset();
        tick_mode    = 2;
        tick_off     = 3;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req      = 4'b0100;
        wait_start();
        chk("wrap_first", 32'(bus.grant), 32'h4);
        wait_end(n);
        bus.req = 4'b0101;
        wait_start();
        chk("wrap_second", 32'(bus.grant), 32'h1);
        chk("wrap_second_din", 32'(bus.tx_din), 32'h11);
        wait_end(n);
        bus.req = 4'b0100;
        wait_start();
        chk("wrap_third", 32'(bus.grant), 32'h4);
        wait_end(n);
        bus.req = '0;

        // Watchdog with a silent transmitter.
        tick_mode = 1;
        repeat (2) @(negedge clk);
        bus.req = 4'b0010;
        wait_start();
        wait_end(n);
        chk("to_latency", 32'(n), 32'd51);
        chk("to_err", 32'(bus.timeout_err), 32'd1);
        chk("to_done", 32'(bus.done), 32'd0);
        bus.req = '0;
        @(negedge clk);
        chk("to_idle", 32'(bus.busy), 32'd0);

        // Done tick on the very cycle the watchdog expires.
        tick_mode = 2;
        tick_off  = TIMEOUT;
        bus.req   = 4'b1000;
        wait_start();
        wait_end(n);
        chk("coin_latency", 32'(n), 32'd51);
        chk("coin_done", 32'(bus.done), 32'h8);
        chk("coin_err", 32'(bus.timeout_err), 32'd0);
        bus.req = '0;

        // Ticks while idle are ignored.
        @(negedge clk);
        tick_mode = 3;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("idle_tick_busy", 32'(bus.busy), 32'd0);
            chk("idle_tick_done", 32'(bus.done), 32'd0);
        end
        tick_mode = 1;

        // Serve requester 2 (ptr -> 3), start it again and reset inside WAIT.
        tick_mode = 2;
        tick_off  = 3;
        bus.req   = 4'b0100;
        wait_start();
        wait_end(n);
        chk("pre_rst_done", 32'(bus.done), 32'h4);
        tick_mode = 1;
        @(negedge clk);
        wait_start();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_din", 32'(bus.tx_din), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        bus.req = 4'b1010;
        @(negedge clk);
        reset     = 1'b0;
        tick_mode = 2;
        tick_off  = 4;
        wait_start();
        chk("post_rst_grant", 32'(bus.grant), 32'h2);
        wait_end(n);
        chk("post_rst_done", 32'(bus.done), 32'h2);
        bus.req = '0;
        repeat (2) @(negedge clk);

        // Randomized requesters and transmitter.
        tick_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       tick_div = 3;
                    1:       tick_div = 12;
                    default: tick_div = 60;
                endcase
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i] && bus.done[i]) begin
                    if ($urandom_range(0, 2) == 0) bus.req_data[8*i +: 8] = 8'($urandom);
                    else                           bus.req[i] = 1'b0;
                end else if (bus.req[i] && bus.grant[i] && $urandom_range(0, 63) == 0) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 7) == 0) begin
                    bus.req_data[8*i +: 8] = 8'($urandom);
                    bus.req[i] = 1'b1;
                end
            end
            @(negedge clk);
        end
        bus.req = '0;
        repeat (120) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one 8N1 UART transmitter between NREQ byte-producing requesters.
- Picks one pending requester and latches its byte. Pulses the transmitter's start strobe, then waits for the transmitter's done tick and returns a per-requester completion pulse.
- Sits between the client blocks (debug printers, status reporters) and the single transmitter/baud-generator pair on the serial pin.
- A watchdog aborts a transfer if the transmitter never reports done.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 200000, clk cycles allowed in WAIT before abort. 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester transmit request, level.
- req_data  input  8*NREQ  byte of requester i on bits [8i+7:8i].
- grant  output  NREQ  one-hot owner of the transmitter, held for the whole transfer.
- done  output  NREQ  one-cycle pulse to the owner when its byte has completed.
- timeout_err  output  1  one-cycle pulse when the watchdog aborts.
- busy  output  1  high in every state except IDLE.
- tx_start  output  1  start strobe to the transmitter, one cycle wide.
- tx_din  output  8  byte to the transmitter, stable from START through WAIT.
- tx_done_tick  input  1  completion tick from the transmitter.

Behaviour:
- Reset values:
  - State IDLE.
  - grant=0, done=0, timeout_err=0, busy=0, tx_start=0, tx_din=0.
  - Round-robin pointer ptr=0, watchdog counter=0.
  - Reset mid-transfer aborts immediately. No done pulse is issued for the aborted byte.
- All outputs are registered.
- IDLE:
  - req is sampled only in this state.
  - If req!=0, the winner is the first set bit searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (wrap-around).
  - At the edge that sees the request: grant<=onehot(winner), tx_din<=req_data[winner], tx_start<=1, busy<=1, state->START.
- START: lasts exactly one cycle with tx_start=1. At the next edge: tx_start<=0, counter<=0, state->WAIT.
- WAIT:
  - tx_done_tick=1: done<=grant, state->DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: timeout_err<=1, state->DONE with done<=0.
  - Otherwise counter increments.
  - If tx_done_tick and the timeout coincide, tx_done_tick wins (done pulse, no error).
- DONE:
  - One cycle; the done or timeout_err pulse is visible in this cycle.
  - At the exit edge: done<=0, timeout_err<=0, grant<=0, busy<=0, ptr<=(owner+1) mod NREQ, state->IDLE.
  - No arbitration happens in DONE.
- Requester protocol:
  - Hold req and req_data stable from assertion until done is seen.
  - Drop req at the edge that samples done=1 unless another byte is queued. If req stays high, the requester re-enters arbitration.
  - Dropping req while granted does not abort the transfer; the byte is still sent and done still pulses.
- tx_done_tick in IDLE, START or DONE is ignored.
- Minimum requester-to-tx_start latency is 1 cycle (the tx_start edge). Back-to-back bytes are separated by the DONE and IDLE cycles, 2 cycles beyond transmitter time.
- Fairness: with all requesters permanently requesting, service order is 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 transfers.
- Widths:
  - ptr and owner index are $clog2(NREQ) bits.
  - The watchdog counter is wide enough to hold TIMEOUT-1; the counter compare width equals the counter width.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5 -> tx_start high 1 cycle after the sampling edge. tx_din=8'hA5 and grant=4'b0100 until DONE. Instantiated transmitter emits 0x A5 LSB-first with start/stop bits. done=4'b0100 for one cycle; busy low afterwards.
- Round-robin: req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13 -> serial output order 10,11,12,13,10; grant sequence 0001,0010,0100,1000,0001.
- Wrap and pointer: after serving requester 2, assert req=4'b0101 -> requester 0 wins (search 3,0). Then requester 2 wins.
- Timeout: TIMEOUT=50, stub tx_done_tick tied low -> timeout_err pulses exactly 50 cycles after WAIT entry; done stays 0; busy drops the next cycle.
- Reset mid-operation: assert reset while in WAIT -> all outputs 0 immediately (asynchronous). No done pulse. After release, req=4'b0010 is granted with ptr=0 search.
- Coincidence and ignore: tx_done_tick on the timeout cycle -> done pulses, timeout_err=0. tx_done_tick while IDLE with req=0 -> no output change.
